// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter
//
// Round-robin arbiter and sequencer that shares one bit-serial adder among
// NREQ requesters. The winner's operands are latched once at the grant edge,
// the adder is started for ADD_LAT cycles, the sum is captured and returned
// with a one-cycle acknowledge, then one cool-down cycle lets the adder see
// START low before the next operation.
//
// Handshake: a requester raises req[i] with a_in/b_in slices valid and holds
// both until ack[i]; req is only sampled in IDLE. ack[i] is a single-cycle
// pulse, and sum_out is valid in that cycle and held until the next ack.
//
// Ports:
//   clk        clock, all state on posedge
//   rst        asynchronous active-high reset
//   req        level request per requester
//   a_in/b_in  packed operands, requester i at [i*SIZE +: SIZE]
//   gnt        one-hot grant, held from grant edge through the ACK cycle
//   ack        one-cycle completion pulse to the granted requester
//   sum_out    captured adder result (SIZE+1 bits, carry in the MSB)
//   busy       high whenever the FSM is not IDLE
//   add_start  adder start, high for exactly ADD_LAT cycles per operation
//   add_a/b    latched operands driven to the adder
//   add_sum    adder result
//   state_dbg  current FSM state (IDLE=0, RUN=1, ACK=2, COOL=3)
module serial_add_arbiter #(
  parameter int SIZE    = 8,
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SIZE-1:0] a_in,
  input  logic [NREQ*SIZE-1:0] b_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic [SIZE:0]        sum_out,
  output logic                 busy,
  output logic                 add_start,
  output logic [SIZE-1:0]      add_a,
  output logic [SIZE-1:0]      add_b,
  input  logic [SIZE:0]        add_sum,
  output logic [1:0]           state_dbg
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(ADD_LAT);
  localparam logic [CW-1:0] CNT_LAST = CW'(ADD_LAT - 1);
  localparam logic [PW-1:0] PTR_RST  = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ACK  = 2'd2,
    S_COOL = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic            any_req;
  int              idx;

  // Round-robin pick: first requesting index starting at ptr+1, with wrap.
  // ptr holds the last winner, so a requester cannot win twice in a row
  // while any other requester is waiting.
  always_comb begin
    win     = ptr;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        win     = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ptr       <= PTR_RST;
      gnt       <= '0;
      ack       <= '0;
      add_start <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      sum_out   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            ptr       <= win;
            add_a     <= a_in[int'(win)*SIZE +: SIZE];
            add_b     <= b_in[int'(win)*SIZE +: SIZE];
            add_start <= 1'b1;
            cnt       <= '0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          // add_start has been high since the grant edge; the sum is
          // sampled on the ADD_LAT-th edge while START is still high.
          if (cnt == CNT_LAST) begin
            sum_out   <= add_sum;
            add_start <= 1'b0;
            ack       <= gnt;
            state     <= S_ACK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ACK: begin
          ack   <= '0;
          gnt   <= '0;
          state <= S_COOL;
        end
        S_COOL: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule
